// File: rtl/aut_pkg.sv
// Shared types and constants for the authentication sequencer.
package aut_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StEval,
    StGrant,
    StDeny,
    StLock
  } aut_state_e;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_1    = 2'd1;
  localparam logic [1:0] LVL_2    = 2'd2;
  localparam logic [1:0] LVL_3    = 2'd3;

  localparam int unsigned TW = 8;

  // AUT1 has the highest priority, AUT3 the lowest.
  function automatic logic [1:0] aut_level(input logic [2:0] aut);
    if (aut[0])      return LVL_1;
    else if (aut[1]) return LVL_2;
    else if (aut[2]) return LVL_3;
    else             return LVL_NONE;
  endfunction

endpackage

// File: rtl/aut_hold_timer.sv
// Loadable down-counter; done marks the last cycle of a hold period.
module aut_hold_timer
  import aut_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] value_i,
  output logic          done_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign done_o = (cnt_q == TW'(1));

endmodule

// File: rtl/aut_sequencer.sv
// Authentication sequencer: capture code, evaluate match lines, hold grant/deny/lockout.
// Optional AUT_ENTER_SYNC_EN: treat enter as a raw button through a synchronizer and edge detector.
module aut_sequencer
  import aut_pkg::*;
#(
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned GRANT_CYCLES = 50,
  parameter int unsigned DENY_CYCLES  = 10,
  parameter int unsigned LOCK_CYCLES  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] code_i,
  input  logic       enter_i,
  input  logic [2:0] aut_i,
  output logic [5:0] cmp_code_o,
  output logic       busy_o,
  output logic       grant_o,
  output logic [1:0] level_o,
  output logic       deny_o,
  output logic       locked_o,
  output logic [3:0] fail_cnt_o
);

  aut_state_e    state_q;
  logic [5:0]    cmp_code_q;
  logic          grant_q, deny_q, locked_q;
  logic [1:0]    level_q;
  logic [3:0]    fail_cnt_q;
  logic          enter_req;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  logic [4:0]    fail_next;

`ifdef AUT_ENTER_SYNC_EN
  logic sync1_q, sync2_q, prev_q, strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= enter_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      strobe_q <= sync2_q & ~prev_q;
    end
  end

  assign enter_req = strobe_q;
`else
  assign enter_req = enter_i;
`endif

  assign fail_next = {1'b0, fail_cnt_q} + 5'd1;
  assign tmr_load  = (state_q == StEval);

  always_comb begin
    tmr_val = TW'(DENY_CYCLES);
    if (aut_i != 3'b000) begin
      tmr_val = TW'(GRANT_CYCLES);
    end else if (fail_next >= 5'(MAX_FAILS)) begin
      tmr_val = TW'(LOCK_CYCLES);
    end
  end

  aut_hold_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .value_i(tmr_val),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmp_code_q <= '0;
      grant_q    <= 1'b0;
      deny_q     <= 1'b0;
      locked_q   <= 1'b0;
      level_q    <= LVL_NONE;
      fail_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enter_req) begin
            cmp_code_q <= code_i;
            state_q    <= StLatch;
          end
        end
        StLatch: state_q <= StEval;
        StEval: begin
          if (aut_i != 3'b000) begin
            level_q    <= aut_level(aut_i);
            grant_q    <= 1'b1;
            fail_cnt_q <= '0;
            state_q    <= StGrant;
          end else if (fail_next < 5'(MAX_FAILS)) begin
            fail_cnt_q <= fail_next[3:0];
            deny_q     <= 1'b1;
            state_q    <= StDeny;
          end else begin
            fail_cnt_q <= 4'(MAX_FAILS);
            locked_q   <= 1'b1;
            state_q    <= StLock;
          end
        end
        StGrant: begin
          if (tmr_done) begin
            grant_q <= 1'b0;
            level_q <= LVL_NONE;
            state_q <= StIdle;
          end
        end
        StDeny: begin
          if (tmr_done) begin
            deny_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StLock: begin
          if (tmr_done) begin
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmp_code_o = cmp_code_q;
  assign busy_o     = (state_q != StIdle);
  assign grant_o    = grant_q;
  assign level_o    = level_q;
  assign deny_o     = deny_q;
  assign locked_o   = locked_q;
  assign fail_cnt_o = fail_cnt_q;

endmodule

// File: tb/tb_aut_sequencer.sv
// Self-checking bench for aut_sequencer: timestamp-based model plus directed literal checks.
module tb_aut_sequencer;

  localparam int MAXF = 3;
  localparam int GC   = 50;
  localparam int DC   = 10;
  localparam int LC   = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] code;
  logic       enter;
  logic [2:0] aut;
  logic [5:0] cmp_code;
  logic       busy, grant, deny, locked;
  logic [1:0] level;
  logic [3:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aut_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_i    (code),
    .enter_i   (enter),
    .aut_i     (aut),
    .cmp_code_o(cmp_code),
    .busy_o    (busy),
    .grant_o   (grant),
    .level_o   (level),
    .deny_o    (deny),
    .locked_o  (locked),
    .fail_cnt_o(fail_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request at edge a shows its outcome from edge a+2 for `hold` cycles.
  int         edge_n = 0;
  int         acc    = 0;
  int         hold   = 0;
  int         kind   = 0;  // 0 grant, 1 deny, 2 lock
  int         m_lvl  = 0;
  int         m_fail = 0;
  bit         active = 0;
  logic [5:0] m_cmp  = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edge_n = 0; active = 0; m_fail = 0; m_cmp = '0; m_lvl = 0; kind = 0;
      end else begin
        edge_n++;
        if (active && edge_n == acc + 2) begin
          m_lvl = aut[0] ? 1 : aut[1] ? 2 : aut[2] ? 3 : 0;
          if (m_lvl != 0) begin
            kind = 0; hold = GC; m_fail = 0;
          end else if (m_fail + 1 < MAXF) begin
            kind = 1; hold = DC; m_fail++;
          end else begin
            kind = 2; hold = LC; m_fail = MAXF;
          end
        end else if (active && edge_n == acc + 2 + hold) begin
          active = 0;
          if (kind == 2) m_fail = 0;
        end else if (!active && enter) begin
          active = 1; acc = edge_n; m_cmp = code; hold = 1 << 30;
        end
      end
    end
  end

  initial begin
    bit ind;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_outputs", {cmp_code, busy, grant, level, deny, locked, fail_cnt}, 0);
      end else begin
        ind = active && (edge_n >= acc + 2);
        chk("cmp_code", cmp_code, m_cmp);
        chk("busy",     busy,     active);
        chk("grant",    grant,    ind && kind == 0);
        chk("level",    level,    (ind && kind == 0) ? m_lvl : 0);
        chk("deny",     deny,     ind && kind == 1);
        chk("locked",   locked,   ind && kind == 2);
        chk("fail_cnt", fail_cnt, m_fail);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drives a one-cycle enter; returns 2ns into cycle T+1.
  task automatic send(input logic [5:0] c, input logic [2:0] a);
    enter = 1'b1; code = c; aut = a;
    step(1);
    enter = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      step(1);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; enter = 1'b0; code = '0; aut = '0;
    step(2);
    chk("reset_busy", busy, 0);
    chk("reset_fail", fail_cnt, 0);
    rst_n = 1'b1;
    step(1);

    // Reset mid-GRANT.
    send(6'b111000, 3'b001);
    step(15);
    chk("pre_rst_grant", grant, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cmp", cmp_code, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Basic grant at level 1.
    send(6'b101101, 3'b001);
    chk("s1_cmp_T1", cmp_code, 6'b101101);
    chk("s1_busy_T1", busy, 1);
    step(1);
    chk("s1_grant_T2", grant, 0);
    step(1);
    chk("s1_grant_T3", grant, 1);
    chk("s1_level_T3", level, 1);
    chk("s1_fail_T3", fail_cnt, 0);
    step(GC - 1);
    chk("s1_grant_last", grant, 1);
    step(1);
    chk("s1_grant_end", grant, 0);
    chk("s1_level_end", level, 0);
    chk("s1_busy_end", busy, 0);
    step(1);

    // AUT2 beats AUT3.
    send(6'b000111, 3'b110);
    step(2);
    chk("s2_grant", grant, 1);
    chk("s2_level", level, 2);
    wait_idle();

    // Three failures into lockout.
    send(6'd1, 3'b000);
    step(2);
    chk("f1_deny", deny, 1);
    chk("f1_cnt", fail_cnt, 1);
    step(DC);
    chk("f1_deny_end", deny, 0);
    wait_idle();
    send(6'd2, 3'b000);
    step(2);
    chk("f2_deny", deny, 1);
    chk("f2_cnt", fail_cnt, 2);
    wait_idle();
    send(6'd3, 3'b000);
    step(2);
    chk("f3_locked", locked, 1);
    chk("f3_cnt", fail_cnt, 3);
    chk("f3_deny", deny, 0);
    step(LC - 1);
    chk("lock_last", locked, 1);
    step(1);
    chk("lock_end", locked, 0);
    chk("lock_end_cnt", fail_cnt, 0);
    chk("lock_end_busy", busy, 0);
    step(1);

    // Two failures then AUT3 clears the count.
    send(6'd4, 3'b000); wait_idle();
    send(6'd5, 3'b000); wait_idle();
    chk("pre3_cnt", fail_cnt, 2);
    send(6'd6, 3'b100);
    step(2);
    chk("s3_level", level, 3);
    chk("s3_cnt", fail_cnt, 0);
    wait_idle();
    send(6'd7, 3'b000);
    step(2);
    chk("s3_fail_deny", deny, 1);
    chk("s3_fail_cnt", fail_cnt, 1);
    wait_idle();

    // Enter hammered during DENY; code changed during LATCH.
    send(6'b010101, 3'b000);
    code = 6'b111111;
    step(2);
    chk("h_deny", deny, 1);
    enter = 1'b1;
    code  = 6'b110011;
    for (int i = 0; i < 20 && busy; i++) begin
      step(1);
      chk("h_cmp_hold", cmp_code, 6'b010101);
    end
    enter = 1'b0;
    step(1);
    chk("h_busy_after", busy, 0);
    chk("h_cmp_after", cmp_code, 6'b010101);
    send(6'b110011, 3'b010);
    chk("h_cmp_new", cmp_code, 6'b110011);
    step(2);
    chk("h_level", level, 2);
    chk("h_cnt", fail_cnt, 0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aut_sequencer.md
Name: aut_sequencer

Overview:
- Sequential controller for the three-output authentication comparator (inputs A..F, outputs AUT1..AUT3).
- Captures a 6-bit user code on an enter strobe and drives it onto the comparator inputs from a register.
- Samples the three match lines, resolves them into an access level, and holds grant or deny indications for fixed durations.
- Counts consecutive failures and forces a timed lockout; sits between the switch/button front end and the door/indicator outputs.

Parameters:
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..15).
- GRANT_CYCLES, 50, cycles grant is held (>=1).
- DENY_CYCLES, 10, cycles deny is held (>=1).
- LOCK_CYCLES, 200, cycles lockout is held (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code  in  6  user code; bit5..bit0 map to A..F.
- enter  in  1  one-cycle synchronous request strobe.
- aut  in  3  comparator match lines; bit0=AUT1, bit1=AUT2, bit2=AUT3.
- cmp_code  out  6  registered code driven to comparator A..F.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  access granted, held GRANT_CYCLES.
- level  out  2  granted level: 1=AUT1, 2=AUT2, 3=AUT3, 0=none.
- deny  out  1  attempt rejected, held DENY_CYCLES.
- locked  out  1  lockout active, held LOCK_CYCLES.
- fail_cnt  out  4  consecutive failures so far.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. All outputs 0, state IDLE, timer 0. Reset in any state aborts immediately.
- States: IDLE, LATCH, EVAL, GRANT, DENY, LOCK.
- IDLE: if enter=1 at edge T, cmp_code<=code and go to LATCH at T+1.
- LATCH: one settle cycle for the combinational comparator; go to EVAL.
- EVAL: sample aut. Priority is AUT1 > AUT2 > AUT3; the lowest set index wins.
  - Any bit set: level<=index+1, grant<=1, fail_cnt<=0, load timer with GRANT_CYCLES, go to GRANT.
  - aut=0 and fail_cnt+1<MAX_FAILS: fail_cnt<=fail_cnt+1, deny<=1, load DENY_CYCLES, go to DENY.
  - aut=0 and fail_cnt+1==MAX_FAILS: fail_cnt<=MAX_FAILS, locked<=1, load LOCK_CYCLES, go to LOCK.
- Latency: grant, deny or locked asserts at T+3 after the enter edge.
- GRANT, DENY and LOCK each hold exactly their parameter count of cycles, then return to IDLE with the indication cleared. level clears together with grant.
- LOCK exit: fail_cnt<=0.
- enter while busy=1 is ignored and not queued. An enter in the same cycle the state returns to IDLE is also ignored; the first accepted enter is in a cycle where the registered state is IDLE.
- code changes after capture have no effect; cmp_code holds its value until the next accepted enter.
- At most one of grant, deny or locked is high at any time.
- fail_cnt never exceeds MAX_FAILS.

Optional Feature:
- Macro: AUT_ENTER_SYNC_EN.
- Defined: enter is treated as a raw asynchronous button level. It passes through a 2-flop synchronizer plus rising-edge detector, and only the detected edge acts as the strobe. This adds 3 cycles of latency (response at T+6 from the raw rising edge); holding the button generates one request only.
- Undefined: enter is used directly as a synchronous strobe, and each high cycle seen in IDLE is a request.

Decomposition:
- Package aut_pkg:
  - state enum (6 states, 3-bit encoding).
  - level constants LVL_NONE, LVL_1, LVL_2, LVL_3.
  - timer width constant TW=8, sized for LOCK_CYCLES≤255.
- Sub-module aut_hold_timer:
  - loadable down-counter with load, value and done=1 when the count reaches 1.
  - one instance is shared by the GRANT, DENY and LOCK states.

Test Plan:
- Reset mid-GRANT (rst_n low for 1 cycle at cycle 20): all outputs 0 asynchronously, state IDLE, next enter accepted normally.
- code=6'b101101, enter at T, aut=3'b001: cmp_code=6'b101101 at T+1, grant=1 and level=1 at T+3 for exactly 50 cycles, fail_cnt=0.
- aut=3'b110 on an accepted enter: level=2 (AUT2 beats AUT3), grant=1.
- aut=0 on three consecutive attempts: deny for 10 cycles with fail_cnt 1, then deny for 10 cycles with fail_cnt 2, then locked=1 for 200 cycles with fail_cnt=3; after LOCK, fail_cnt=0 and busy=0.
- Two failures followed by aut=3'b100: grant with level=3 and fail_cnt cleared to 0; a later failure gives fail_cnt=1, not lockout.
- enter pulsed every cycle during DENY, and code changed during LATCH: no extra requests are accepted and cmp_code is unchanged until the first enter in IDLE.
